// File: rtl/bnn_layer_collector_if.sv
// Handshake and result bundle for bnn_layer_collector.
//   master : producer/observer side (drives in_valid, in_bit, flush)
//   slave  : collector side (drives in_ready, out_*, seg, busy)
// Signals:
//   in_valid/in_bit/in_ready : serial neuron bit stream with ready handshake
//   flush                    : abandon the partial frame
//   out_valid                : one-cycle pulse when results update
//   out_vec/out_count        : last completed frame and its popcount
//   out_fire                 : popcount threshold decision
//   seg                      : seven-segment (a..g = bit 0..6) hex of out_count
//   busy                     : frame partially collected
interface bnn_layer_collector_if #(
    parameter int N_NEURONS = 8
);
    localparam int CW = $clog2(N_NEURONS + 1);

    logic                 in_valid;
    logic                 in_bit;
    logic                 in_ready;
    logic                 flush;
    logic                 out_valid;
    logic [N_NEURONS-1:0] out_vec;
    logic [CW-1:0]        out_count;
    logic                 out_fire;
    logic [6:0]           seg;
    logic                 busy;

    modport master (
        output in_valid, in_bit, flush,
        input  in_ready, out_valid, out_vec, out_count, out_fire, seg, busy
    );

    modport slave (
        input  in_valid, in_bit, flush,
        output in_ready, out_valid, out_vec, out_count, out_fire, seg, busy
    );
endinterface

// File: rtl/bnn_layer_collector.sv
// Collects one binary neuron output per accepted beat into an N_NEURONS-bit
// frame (first bit -> out_vec[0]). On completion it publishes the vector, its
// popcount, a popcount >= THRESH fire flag and a hex seven-segment pattern.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : bnn_layer_collector_if slave modport (handshake + results)
module bnn_layer_collector #(
    parameter int N_NEURONS = 8,
    parameter int THRESH    = 4
) (
    input  logic clk,
    input  logic rst,
    bnn_layer_collector_if.slave bus
);
    localparam int CW = $clog2(N_NEURONS + 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

    state_t               state, state_next;
    logic [CW-1:0]        idx, idx_next;
    logic [N_NEURONS-1:0] shreg, shreg_next;
    logic [CW-1:0]        pop_next;
    logic                 in_ready;
    logic                 accept;
    logic                 publish;

    logic [N_NEURONS-1:0] out_vec;
    logic [CW-1:0]        out_count;
    logic                 out_fire;
    logic [6:0]           seg;

    function automatic logic [6:0] hex_seg(input logic [3:0] d);
        case (d)
            4'h0:    return 7'b0111111;
            4'h1:    return 7'b0000110;
            4'h2:    return 7'b1011011;
            4'h3:    return 7'b1001111;
            4'h4:    return 7'b1100110;
            4'h5:    return 7'b1101101;
            4'h6:    return 7'b1111101;
            4'h7:    return 7'b0000111;
            4'h8:    return 7'b1111111;
            4'h9:    return 7'b1101111;
            4'hA:    return 7'b1110111;
            4'hB:    return 7'b1111100;
            4'hC:    return 7'b0111001;
            4'hD:    return 7'b1011110;
            4'hE:    return 7'b1111001;
            default: return 7'b1110001;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        in_ready   = (state != DONE);
        accept     = bus.in_valid && in_ready && !bus.flush;
        state_next = state;
        idx_next   = idx;
        shreg_next = shreg;
        publish    = 1'b0;
        pop_next   = '0;

        case (state)
            IDLE, COLLECT: begin
                if (accept) begin
                    for (int unsigned i = 0; i < N_NEURONS; i++) begin
                        if (idx == CW'(i)) shreg_next[i] = bus.in_bit;
                    end
                    // Results are registered on the accepting edge so they are
                    // already valid during the single DONE cycle.
                    if (idx == CW'(N_NEURONS - 1)) begin
                        state_next = DONE;
                        idx_next   = '0;
                        publish    = 1'b1;
                    end else begin
                        state_next = COLLECT;
                        idx_next   = idx + CW'(1);
                    end
                end else if (state == COLLECT && bus.flush) begin
                    state_next = IDLE;
                    idx_next   = '0;
                    shreg_next = '0;
                end
            end
            DONE: begin
                state_next = IDLE;
                shreg_next = '0;
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
                shreg_next = '0;
            end
        endcase

        for (int unsigned i = 0; i < N_NEURONS; i++) begin
            pop_next = pop_next + CW'(shreg_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            shreg     <= '0;
            out_vec   <= '0;
            out_count <= '0;
            out_fire  <= 1'b0;
            seg       <= '0;
        end else begin
            idx   <= idx_next;
            shreg <= shreg_next;
            if (publish) begin
                out_vec   <= shreg_next;
                out_count <= pop_next;
                out_fire  <= (pop_next >= CW'(THRESH));
                seg       <= hex_seg(4'(pop_next));
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == COLLECT);
    assign bus.out_vec   = out_vec;
    assign bus.out_count = out_count;
    assign bus.out_fire  = out_fire;
    assign bus.seg       = seg;
endmodule

// File: tb/tb_bnn_layer_collector.sv
// Self-checking bench for bnn_layer_collector: a queue-based frame model is
// compared against every DUT output on each falling edge, directed scenarios
// pin literal results, and a random soak mixes gaps, flushes and resets.
module tb_bnn_layer_collector;
    localparam int N  = 8;
    localparam int TH = 4;
    localparam int CW = $clog2(N + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bnn_layer_collector_if #(.N_NEURONS(N)) bus ();

    bnn_layer_collector #(.N_NEURONS(N), .THRESH(TH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [6:0] seg_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    // Behavioural model: a queue of bits accepted so far in the current frame
    bit         q[$];
    bit         m_done  = 1'b0;
    logic [N-1:0] m_vec = '0;
    int         m_count = 0;
    bit         m_fire  = 1'b0;
    logic [6:0] m_seg   = '0;
    bit         armed   = 1'b0;
    int         cyc     = 0;
    int         valid_cycles[$];

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            m_done  = 1'b0;
            m_vec   = '0;
            m_count = 0;
            m_fire  = 1'b0;
            m_seg   = '0;
            armed   = 1'b1;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (bus.flush) begin
            q.delete();
        end else if (bus.in_valid) begin
            q.push_back(bus.in_bit);
            if (q.size() == N) begin
                m_vec   = '0;
                m_count = 0;
                foreach (q[i]) begin
                    m_vec[i] = q[i];
                    m_count += int'(q[i]);
                end
                m_fire = (m_count >= TH);
                m_seg  = seg_tab[m_count];
                m_done = 1'b1;
                q.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("in_ready",  32'(bus.in_ready),  32'(!m_done));
            check("busy",      32'(bus.busy),      32'(q.size() != 0));
            check("out_valid", 32'(bus.out_valid), 32'(m_done));
            check("out_vec",   32'(bus.out_vec),   32'(m_vec));
            check("out_count", 32'(bus.out_count), 32'(m_count));
            check("out_fire",  32'(bus.out_fire),  32'(m_fire));
            check("seg",       32'(bus.seg),       32'(m_seg));
            if (bus.out_valid) valid_cycles.push_back(cyc);
        end
    end

    // Apply inputs, let one rising edge consume them, return just after it
    task automatic cycle(input bit v, input bit b, input bit f, input bit r);
        bus.in_valid = v;
        bus.in_bit   = b;
        bus.flush    = f;
        rst          = r;
        @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input bit b, input int gap);
        repeat (gap) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4 && !bus.in_ready; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        if (!bus.in_ready) check("ready_timeout", 32'(bus.in_ready), 32'd1);
        cycle(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [N-1:0] v, input int maxgap);
        for (int i = 0; i < N; i++)
            send_bit(v[i], (maxgap > 0 && i > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic wait_valid();
        for (int k = 0; k < 4 && !bus.out_valid; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("out_valid_seen", 32'(bus.out_valid), 32'd1);
    endtask

    initial begin
        logic [N-1:0] v;
        int base;
        int not_ready;

        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        bus.flush    = 1'b0;

        // 1: reset, then the reference frame 1,0,1,1,0,0,1,0
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_vec",   32'(bus.out_vec),   32'h0);
        check("rst_seg",   32'(bus.seg),       32'h0);
        check("rst_ready", 32'(bus.in_ready),  32'd1);
        check("rst_busy",  32'(bus.busy),      32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        send_frame(8'h4D, 0);
        wait_valid();
        check("t1_vec",   32'(bus.out_vec),   32'h4D);
        check("t1_count", 32'(bus.out_count), 32'd4);
        check("t1_fire",  32'(bus.out_fire),  32'd1);
        check("t1_seg",   32'(bus.seg),       32'(7'b1100110));
        check("t1_model_vec", 32'(m_vec),   32'h4D);
        check("t1_model_seg", 32'(m_seg),   32'(7'b1100110));

        // 2: all-zero and all-one frames
        send_frame(8'h00, 0);
        wait_valid();
        check("t2_zero_count", 32'(bus.out_count), 32'd0);
        check("t2_zero_fire",  32'(bus.out_fire),  32'd0);
        check("t2_zero_seg",   32'(bus.seg),       32'(7'b0111111));
        send_frame(8'hFF, 0);
        wait_valid();
        check("t2_ones_count", 32'(bus.out_count), 32'd8);
        check("t2_ones_fire",  32'(bus.out_fire),  32'd1);
        check("t2_ones_seg",   32'(bus.seg),       32'(7'b1111111));
        check("t2_model_cnt",  32'(m_count),       32'd8);

        // 3: partial frame abandoned by flush
        for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
        check("t3_busy_before", 32'(bus.busy), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_busy_after",  32'(bus.busy),      32'd0);
        check("t3_no_valid",    32'(bus.out_valid), 32'd0);
        check("t3_hold_count",  32'(bus.out_count), 32'd8);
        send_frame(8'h07, 0);
        wait_valid();
        check("t3_count", 32'(bus.out_count), 32'd3);
        check("t3_fire",  32'(bus.out_fire),  32'd0);
        check("t3_seg",   32'(bus.seg),       32'(7'b1001111));

        // 4: in_valid held high across two back-to-back frames
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        base = valid_cycles.size();
        not_ready = 0;
        for (int i = 0; i < 18; i++) begin
            cycle(1'b1, 1'($urandom), 1'b0, 1'b0);
            if (i < 9 && !bus.in_ready) not_ready++;
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_not_ready_cycles", 32'(not_ready), 32'd1);
        check("t4_pulses", 32'(valid_cycles.size() - base), 32'd2);
        if (valid_cycles.size() >= base + 2)
            check("t4_period", 32'(valid_cycles[base+1] - valid_cycles[base]), 32'd9);

        // 5: reset mid-frame
        for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_count", 32'(bus.out_count), 32'd0);
        check("t5_seg",   32'(bus.seg),       32'h0);
        check("t5_busy",  32'(bus.busy),      32'd0);
        check("t5_ready", 32'(bus.in_ready),  32'd1);
        v = N'($urandom);
        send_frame(v, 0);
        wait_valid();
        check("t5_vec",   32'(bus.out_vec),   32'(v));
        check("t5_pop",   32'(bus.out_count), 32'($countones(v)));

        // 6: random idle gaps between bits
        for (int r = 0; r < 4; r++) begin
            v = N'($urandom);
            send_frame(v, 4);
            wait_valid();
            check("t6_vec", 32'(bus.out_vec), 32'(v));
        end

        // Random soak: valid/bit/flush/reset mixed
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, 1'($urandom),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bnn_layer_collector.md
Name: bnn_layer_collector

Overview:
Downstream stage of the BNN neuron. Serially collects one binary output bit per neuron for a full layer frame of N_NEURONS bits. On frame completion it reports:
- the layer vector,
- its popcount,
- a threshold "fire" decision,
- a seven-segment rendering of the popcount for the uo_out display pins.

Parameters:
N_NEURONS, 8, bits per frame; legal range 1..15 so the count fits one hex digit.
THRESH, 4, fire when popcount >= THRESH; legal range 0..N_NEURONS.
CW, $clog2(N_NEURONS+1), count width; derived, never overridden.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  neuron output bit presented this cycle.
in_bit  in  1  neuron output bit (1 = +1, 0 = -1).
in_ready  out  1  collector accepts a bit this cycle.
flush  in  1  abandon the partial frame.
out_valid  out  1  one-cycle pulse: result outputs updated.
out_vec  out  N_NEURONS  last completed frame; first accepted bit in out_vec[0].
out_count  out  CW  popcount of out_vec.
out_fire  out  1  out_count >= THRESH.
seg  out  7  active-high segments, seg[0]=a … seg[6]=g, showing out_count in hex.
busy  out  1  frame in progress (at least one bit accepted, frame incomplete).

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; bit index=0; shift register=0.
  - out_valid=0, out_vec=0, out_count=0, out_fire=0, seg=7'b0000000 (blank), busy=0, in_ready=1.
  - rst has priority over every other input, including mid-frame and during DONE.
- Accept rule: a bit is accepted iff in_valid && in_ready && !flush at the clock edge. Accepted bit is written to position idx; idx increments.
- in_ready is combinational from state: 1 in IDLE and COLLECT, 0 in DONE.
- States:
  - IDLE: idx=0, busy=0.
    - Accept with N_NEURONS>1 -> COLLECT.
    - Accept with N_NEURONS=1 -> DONE.
  - COLLECT: busy=1.
    - Accept at idx=N_NEURONS-1 -> DONE.
    - flush -> IDLE with idx=0; the partial frame is discarded and result outputs are unchanged.
  - DONE: lasts exactly one cycle.
    - Registers out_vec ← shift reg, out_count ← popcount, out_fire, seg.
    - out_valid=1 during that same cycle. in_valid is ignored (not accepted, not queued).
    - Next state IDLE; shift reg cleared.
- Latency: the last bit accepted at edge k gives out_valid=1 and updated results in the cycle after edge k (visible after edge k+1). Minimum frame period is N_NEURONS+1 cycles.
- flush in IDLE has no effect. flush in DONE has no effect: the result still publishes.
- Results hold their values between frames until the next DONE; only out_valid pulses.
- Popcount: unsigned sum of out_vec bits, CW bits wide, no overflow possible.
- seg hex table (g..a): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- No combinational path from in_* to out_* other than in_ready (which depends on state only).

Test Plan:
1. rst high 2 cycles -> all outputs zero, seg=0000000, in_ready=1, busy=0; then 8 bits 1,0,1,1,0,0,1,0 with in_valid=1 continuously -> one cycle after the 8th, out_valid=1, out_vec=8'h4D, out_count=4, out_fire=1, seg=1100110.
2. 8 zero bits -> out_vec=0, out_count=0, out_fire=0, seg=0111111. 8 one bits -> out_count=8, out_fire=1, seg=1111111.
3. Accept 3 bits, pulse flush -> busy drops, no out_valid, outputs keep the previous frame. Next 8 bits 1,1,1,0,0,0,0,0 -> out_count=3, out_fire=0, seg=1001111.
4. in_valid held high across two back-to-back frames -> in_ready=0 for exactly one cycle (DONE). The bit offered in that cycle is dropped. The second frame's out_valid arrives 9 cycles after the first.
5. rst asserted after 5 accepted bits -> state returns to IDLE, outputs reset to blank/zero. A following full frame publishes only its own 8 bits.
6. in_valid=0 gaps of random length between bits -> result identical to gapless delivery; busy stays 1 throughout the gaps.
